md_unit: RTL and testbench

MD_UNIT -- requirements
Module: md_unit

---
 rtl/md_unit_pkg.sv | 33 +++
 rtl/md_div_core.sv | 37 +++
 rtl/md_unit.sv | 122 ++++++++++++
 tb/tb_md_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states,
// counter width and default latencies.
package md_unit_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_t;

    localparam int MD_CNT_W       = 4;
    localparam int MD_MUL_LAT_DEF = 5;
    localparam int MD_DIV_LAT_DEF = 10;

    typedef logic [MD_CNT_W-1:0] md_cnt_t;

    // True for the divide family (DIV, DIVU).
    function automatic logic md_is_div(input md_op_t o);
        return (o == MD_DIV) || (o == MD_DIVU);
    endfunction

    // True for the signed variants (MULT, DIV).
    function automatic logic md_is_signed(input md_op_t o);
        return (o == MD_MULT) || (o == MD_DIV);
    endfunction

endpackage

// File: rtl/md_div_core.sv
// Combinational 32-bit divider. Works on magnitudes and restores signs
// afterwards: quotient truncates toward zero, remainder follows the dividend.
module md_div_core (
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        is_signed,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_zero
);

    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] safe_b;
    logic [31:0] mag_q;
    logic [31:0] mag_r;

    // Magnitude divide followed by sign fix-up; zero divisor is flagged and
    // replaced by 1 so the arithmetic never sees a divide by zero.
    always_comb begin
        // NOTE: every output of an always_comb is assigned on every path, so no latch is inferred.
        neg_a    = is_signed & dividend[31];
        neg_b    = is_signed & divisor[31];
        mag_a    = neg_a ? (~dividend + 32'd1) : dividend;
        mag_b    = neg_b ? (~divisor + 32'd1) : divisor;
        div_zero = (divisor == 32'd0);
        safe_b   = div_zero ? 32'd1 : mag_b;
        mag_q    = mag_a / safe_b;
        mag_r    = mag_a % safe_b;
        // 0x80000000 / -1 yields magnitude 0x80000000, whose negation is itself.
        quotient  = (neg_a ^ neg_b) ? (~mag_q + 32'd1) : mag_q;
        remainder = neg_a ? (~mag_r + 32'd1) : mag_r;
    end

endmodule

// File: rtl/md_unit.sv
// HI/LO multiply/divide unit. Result is computed when the op is accepted,
// held in pending registers, and committed to HI/LO after a fixed latency.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MUL_LAT = MD_MUL_LAT_DEF,
    parameter int DIV_LAT = MD_DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        we_hi,
    input  logic        we_lo,
    input  logic [31:0] wdata,
    input  logic        md_use_D,
    output logic [31:0] HI_E,
    output logic [31:0] LO_E,
    output logic        busy,
    output logic        stall_md
);

    md_op_t      op_in;
    md_state_t   state;
    md_cnt_t     cnt;
    md_op_t      op_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    logic        pend_zero;
    logic        busy_q;

    logic [63:0] mul_res;
    logic [31:0] div_quo;
    logic [31:0] div_rem;
    logic        div_zero;
    logic [31:0] next_hi;
    logic [31:0] next_lo;

    assign op_in = md_op_t'(op);

    md_div_core u_div (
        .dividend  (A),
        .divisor   (B),
        .is_signed (md_is_signed(op_in)),
        .quotient  (div_quo),
        .remainder (div_rem),
        .div_zero  (div_zero)
    );

    // Inline 64-bit multiply and selection of the value to park in pending.
    always_comb begin
        if (md_is_signed(op_in)) begin
            mul_res = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        end else begin
            mul_res = {32'd0, A} * {32'd0, B};
        end
        if (md_is_div(op_in)) begin
            next_hi = div_rem;
            next_lo = div_quo;
        end else begin
            next_hi = mul_res[63:32];
            next_lo = mul_res[31:0];
        end
    end

    // IDLE/BUSY control, latency counter, pending results and HI/LO state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: pending registers are reset too, so an aborted op leaves nothing stale behind.
            state     <= ST_IDLE;
            cnt       <= '0;
            op_q      <= MD_MULT;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi   <= '0;
            pend_lo   <= '0;
            pend_zero <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        // start wins over a same-cycle mthi/mtlo strobe
                        op_q      <= op_in;
                        pend_hi   <= next_hi;
                        pend_lo   <= next_lo;
                        pend_zero <= md_is_div(op_in) & div_zero;
                        cnt       <= md_is_div(op_in) ? md_cnt_t'(DIV_LAT) : md_cnt_t'(MUL_LAT);
                        busy_q    <= 1'b1;
                        state     <= ST_BUSY;
                    end else begin
                        if (we_hi) hi_q <= wdata;
                        if (we_lo) lo_q <= wdata;
                    end
                end
                ST_BUSY: begin
                    cnt <= cnt - md_cnt_t'(1);
                    if (cnt == md_cnt_t'(1)) begin
                        // a divide by zero runs full length but leaves HI/LO alone
                        if (!(md_is_div(op_q) && pend_zero)) begin
                            hi_q <= pend_hi;
                            lo_q <= pend_lo;
                        end
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign HI_E     = hi_q;
    assign LO_E     = lo_q;
    assign busy     = busy_q;
    assign stall_md = md_use_D & (busy_q | start);

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases plus randomized ops
// compared against a plain-arithmetic model of HI/LO.
module tb_md_unit;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        we_hi;
    logic        we_lo;
    logic [31:0] wdata;
    logic        md_use_D;
    logic [31:0] HI_E;
    logic [31:0] LO_E;
    logic        busy;
    logic        stall_md;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    md_unit #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .A        (A),
        .B        (B),
        .we_hi    (we_hi),
        .we_lo    (we_lo),
        .wdata    (wdata),
        .md_use_D (md_use_D),
        .HI_E     (HI_E),
        .LO_E     (LO_E),
        .busy     (busy),
        .stall_md (stall_md)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Architectural result of an op: HI/LO after completion.
    function automatic void model_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                     inout logic [31:0] hi, inout logic [31:0] lo);
        longint sa, sb, sq, sr;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        case (o)
            2'd0: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
            2'd1: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
            2'd2: if (b != 0) begin sq = sa / sb; sr = sa % sb; lo = sq[31:0]; hi = sr[31:0]; end
            default: if (b != 0) begin lo = a / b; hi = a % b; end
        endcase
    endfunction

    // Issue one op at the current negedge; checks busy length, HI/LO hold and result.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input bit poke_we, input string name);
        int n;
        int lat;
        bit held;
        lat = (o < 2) ? MUL_LAT : DIV_LAT;
        start = 1'b1; op = o; A = a; B = b;
        @(negedge clk);
        start = 1'b0; A = $urandom; B = $urandom;
        n = 0;
        held = 1'b1;
        while (busy === 1'b1 && n < 40) begin
            if (HI_E !== model_hi || LO_E !== model_lo) held = 1'b0;
            if (poke_we) begin
                we_hi = 1'b1; we_lo = 1'b1; wdata = $urandom;
                start = $urandom_range(0, 1);
            end
            n++;
            @(negedge clk);
        end
        we_hi = 1'b0; we_lo = 1'b0; start = 1'b0;
        checks++;
        if (n != lat) begin
            errors++;
            $display("FAIL %s busy_cycles got %0d expected %0d", name, n, lat);
        end
        checks++;
        if (!held) begin
            errors++;
            $display("FAIL %s hilo_hold changed during busy, expected %h/%h", name, model_hi, model_lo);
        end
        model_hi = exp_hi;
        model_lo = exp_lo;
        checks++;
        if (HI_E !== exp_hi || LO_E !== exp_lo) begin
            errors++;
            $display("FAIL %s result got HI=%h LO=%h expected HI=%h LO=%h", name, HI_E, LO_E, exp_hi, exp_lo);
        end
    endtask

    // mthi/mtlo in IDLE.
    task automatic do_mt(input logic wh, input logic wl, input logic [31:0] d, input string name);
        we_hi = wh; we_lo = wl; wdata = d;
        @(negedge clk);
        we_hi = 1'b0; we_lo = 1'b0;
        if (wh) model_hi = d;
        if (wl) model_lo = d;
        checks++;
        if (HI_E !== model_hi || LO_E !== model_lo) begin
            errors++;
            $display("FAIL %s got HI=%h LO=%h expected HI=%h LO=%h", name, HI_E, LO_E, model_hi, model_lo);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; op = 2'd0; A = '0; B = '0;
        we_hi = 1'b0; we_lo = 1'b0; wdata = '0; md_use_D = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || HI_E !== 32'd0 || LO_E !== 32'd0 || stall_md !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got busy=%b HI=%h LO=%h stall=%b expected 0/0/0/0", busy, HI_E, LO_E, stall_md);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (stall_md !== 1'b0) begin
            errors++;
            $display("FAIL idle_stall got %b expected 0", stall_md);
        end
        md_use_D = 1'b0;
        model_hi = '0;
        model_lo = '0;
    endtask

    task automatic test_mt_writes();
        do_mt(1'b1, 1'b0, 32'hA5A5_0001, "mthi");
        do_mt(1'b0, 1'b1, 32'h5A5A_0002, "mtlo");
        do_mt(1'b1, 1'b1, 32'hCAFE_F00D, "mthi_mtlo");
    endtask

    task automatic test_directed();
        do_op(2'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, "mult_neg");
        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu_max");
        do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_neg7");
        do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, "div_ovf");
        do_op(2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "divu_small");
        do_mt(1'b1, 1'b0, 32'h0000_1234, "mthi_1234");
        do_mt(1'b0, 1'b1, 32'h0000_5678, "mtlo_5678");
        do_op(2'd3, 32'hDEAD_BEEF, 32'd0, 32'h0000_1234, 32'h0000_5678, 1'b0, "divu_zero");
        do_op(2'd2, 32'h8765_4321, 32'd0, 32'h0000_1234, 32'h0000_5678, 1'b0, "div_zero");
    endtask

    // start and mthi in the same idle cycle: the op is taken, the write dropped;
    // strobes while busy are ignored as well.
    task automatic test_start_vs_we();
        we_hi = 1'b1; we_lo = 1'b1; wdata = 32'h1111_2222;
        do_op(2'd1, 32'd6, 32'd7, 32'd0, 32'd42, 1'b1, "start_beats_we");
    endtask

    // Back-to-back ops, second start in the very cycle the first completes.
    task automatic test_back_to_back();
        do_op(2'd0, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "b2b_first");
        do_op(2'd3, 32'd50, 32'd8, 32'd2, 32'd6, 1'b0, "b2b_second");
    endtask

    task automatic test_stall();
        int n;
        logic [31:0] eh, el;
        eh = model_hi; el = model_lo;
        model_op(2'd0, 32'h0001_0000, 32'h0003_0000, eh, el);
        md_use_D = 1'b1; start = 1'b1; op = 2'd0; A = 32'h0001_0000; B = 32'h0003_0000;
        #1;
        n = 0;
        while (stall_md === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
            start = (n == 2);
            op = 2'd1; A = $urandom; B = $urandom;
            #1;
        end
        start = 1'b0;
        checks++;
        if (n != 1 + MUL_LAT) begin
            errors++;
            $display("FAIL stall_len got %0d expected %0d", n, 1 + MUL_LAT);
        end
        checks++;
        if (HI_E !== eh || LO_E !== el) begin
            errors++;
            $display("FAIL stall_release got HI=%h LO=%h expected HI=%h LO=%h", HI_E, LO_E, eh, el);
        end
        md_use_D = 1'b0;
        model_hi = eh; model_lo = el;
        repeat (DIV_LAT + 2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || HI_E !== eh || LO_E !== el) begin
            errors++;
            $display("FAIL busy_start_ignored got busy=%b HI=%h LO=%h expected 0 %h %h", busy, HI_E, LO_E, eh, el);
        end
    endtask

    task automatic test_reset_busy();
        do_mt(1'b1, 1'b1, 32'h7777_8888, "pre_abort_mt");
        start = 1'b1; op = 2'd2; A = 32'd1000; B = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_hi = '0; model_lo = '0;
        checks++;
        if (busy !== 1'b0 || HI_E !== 32'd0 || LO_E !== 32'd0) begin
            errors++;
            $display("FAIL abort_reset got busy=%b HI=%h LO=%h expected 0/0/0", busy, HI_E, LO_E);
        end
        repeat (DIV_LAT + 3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || HI_E !== 32'd0 || LO_E !== 32'd0) begin
            errors++;
            $display("FAIL abort_no_update got busy=%b HI=%h LO=%h expected 0/0/0", busy, HI_E, LO_E);
        end
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] a, b, eh, el;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                do_mt($urandom_range(0, 1), $urandom_range(0, 1), $urandom, "rand_mt");
            end else begin
                o = 2'($urandom_range(0, 3));
                a = $urandom;
                case ($urandom_range(0, 3))
                    0: b = 32'd0;
                    1: b = 32'($urandom_range(1, 20));
                    2: b = -32'($urandom_range(1, 20));
                    default: b = $urandom;
                endcase
                eh = model_hi; el = model_lo;
                model_op(o, a, b, eh, el);
                do_op(o, a, b, eh, el, $urandom_range(0, 1), "rand_op");
            end
        end
    endtask

    initial begin
        test_reset();
        test_mt_writes();
        test_directed();
        test_start_vs_we();
        test_back_to_back();
        test_stall();
        test_reset_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
